// File: rtl/alu_ccr_pipe.sv
// Execute-stage ALU with one register stage and a condition-code register {V,C,N,Z}.
// Carry-in ops and rotates read the stored C flag, so chained ops need no bubble.
module alu_ccr_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [3:0]       alu_fun,
    input  logic [1:0]       sub_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_we,
    input  logic [3:0]       flag_din,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic [3:0]       flags,
    output logic             illegal_op
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_UNARY = 4'b0100;
    localparam logic [3:0] OP_CARRY = 4'b0101;
    localparam logic [3:0] OP_ADC   = 4'b0110;
    localparam logic [3:0] OP_SBC   = 4'b0111;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Signed overflow of A+B: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        add_ovf = (a_msb == b_msb) & (r_msb != a_msb);
    endfunction

    // Signed overflow of A-B: operands differ in sign, result left A's sign.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        sub_ovf = (a_msb != b_msb) & (r_msb != a_msb);
    endfunction

    logic             out_valid_r;
    logic [WIDTH-1:0] alu_out_r;
    logic [3:0]       ccr_r;
    logic             illegal_op_r;

    logic             c_cur_s;
    logic             cin_add_s;
    logic             cin_sub_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             z_s;
    logic             n_s;
    logic             zn_upd_s;
    logic             illegal_s;
    logic [3:0]       ccr_op_s;
    logic             accept_s;

    assign c_cur_s  = ccr_r[2];
    assign accept_s = in_valid & ~stall;

    // Shared adder/subtractor; the carry-in is the stored C only for ADC/SBC.
    always_comb begin
        if (alu_fun == OP_ADC) begin
            cin_add_s = c_cur_s;
        end else begin
            cin_add_s = 1'b0;
        end
        if (alu_fun == OP_SBC) begin
            cin_sub_s = c_cur_s;
        end else begin
            cin_sub_s = 1'b0;
        end
        add_s = {1'b0, a} + {1'b0, b} + {ZERO_W, cin_add_s};
        sub_s = {1'b0, a} - {1'b0, b} - {ZERO_W, cin_sub_s};
    end

    // Result and flag selection for the op on the inputs.
    always_comb begin
        res_s     = ZERO_W;
        c_s       = ccr_r[2];
        v_s       = ccr_r[3];
        zn_upd_s  = 1'b0;
        illegal_s = 1'b0;
        case (alu_fun)
            OP_ADD, OP_ADC: begin
                res_s    = add_s[WIDTH-1:0];
                c_s      = add_s[WIDTH];
                v_s      = add_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]);
                zn_upd_s = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                // Bit WIDTH of the wide difference is the borrow.
                res_s    = sub_s[WIDTH-1:0];
                c_s      = sub_s[WIDTH];
                v_s      = sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_s[WIDTH-1]);
                zn_upd_s = 1'b1;
            end
            OP_AND: begin
                res_s    = a & b;
                zn_upd_s = 1'b1;
            end
            OP_OR: begin
                res_s    = a | b;
                zn_upd_s = 1'b1;
            end
            OP_UNARY: begin
                zn_upd_s = 1'b1;
                case (sub_op)
                    2'd0:    res_s = ~b;
                    2'd1:    res_s = ZERO_W - b;
                    2'd2:    res_s = b + ONE_W;
                    2'd3:    res_s = b - ONE_W;
                    default: res_s = ZERO_W;
                endcase
            end
            OP_CARRY: begin
                case (sub_op)
                    2'd0: begin
                        res_s = {b[WIDTH-2:0], c_cur_s};
                        c_s   = b[WIDTH-1];
                    end
                    2'd1: begin
                        res_s = {c_cur_s, b[WIDTH-1:1]};
                        c_s   = b[0];
                    end
                    2'd2: begin
                        res_s = b;
                        c_s   = 1'b1;
                    end
                    2'd3: begin
                        res_s = b;
                        c_s   = 1'b0;
                    end
                    default: begin
                        res_s = b;
                        c_s   = c_cur_s;
                    end
                endcase
            end
            default: begin
                illegal_s = 1'b1;
                res_s     = ZERO_W;
            end
        endcase
    end

    // Z/N follow the result only for ops that define them; illegal ops leave the CCR alone.
    always_comb begin
        if (zn_upd_s) begin
            z_s = (res_s == ZERO_W);
            n_s = res_s[WIDTH-1];
        end else begin
            z_s = ccr_r[0];
            n_s = ccr_r[1];
        end
        if (illegal_s) begin
            ccr_op_s = ccr_r;
        end else begin
            ccr_op_s = {v_s, c_s, n_s, z_s};
        end
    end

    // Pipeline register and CCR; a restore via flag_we outranks the op's flag update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            alu_out_r    <= ZERO_W;
            ccr_r        <= 4'b0000;
            illegal_op_r <= 1'b0;
        end else if (stall) begin
            out_valid_r  <= out_valid_r;
            alu_out_r    <= alu_out_r;
            ccr_r        <= ccr_r;
            illegal_op_r <= illegal_op_r;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            alu_out_r    <= res_s;
            illegal_op_r <= illegal_s;
            ccr_r        <= flag_we ? flag_din : ccr_op_s;
        end else begin
            out_valid_r  <= 1'b0;
            alu_out_r    <= alu_out_r;
            illegal_op_r <= 1'b0;
            ccr_r        <= flag_we ? flag_din : ccr_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign alu_out    = alu_out_r;
    assign flags      = ccr_r;
    assign illegal_op = illegal_op_r;

endmodule

// File: tb/tb_alu_ccr_pipe.sv
// Scoreboard bench for alu_ccr_pipe (WIDTH=8): an integer reference model pushes
// expected results when ops are driven; each test pops and compares after the edge.
module tb_alu_ccr_pipe;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       in_valid;
    logic [3:0] alu_fun;
    logic [1:0] sub_op;
    logic [7:0] a;
    logic [7:0] b;
    logic       flag_we;
    logic [3:0] flag_din;
    logic       out_valid;
    logic [7:0] alu_out;
    logic [3:0] flags;
    logic       illegal_op;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        logic       ill;
    } exp_t;

    exp_t       sb[$];
    exp_t       exp_v;
    logic [3:0] ccr_m;
    logic [7:0] last_r;
    int         n_run;
    int         n_fail;

    alu_ccr_pipe #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid),
        .alu_fun(alu_fun), .sub_op(sub_op), .a(a), .b(b),
        .flag_we(flag_we), .flag_din(flag_din), .out_valid(out_valid),
        .alu_out(alu_out), .flags(flags), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic int sval(input int u);
        sval = (u > 127) ? u - 256 : u;
    endfunction

    // Reference model for an accepted op: integer arithmetic, signed-range overflow.
    task automatic push_op(input logic [3:0] fun, input logic [1:0] sop, input logic [7:0] av,
                           input logic [7:0] bv, input logic we, input logic [3:0] din);
        int ia, ib, cin, s, sr;
        logic [7:0] r;
        logic z, n, c, v, ill, zn;
        exp_t e;
        ia = av; ib = bv; cin = ccr_m[2];
        z = ccr_m[0]; n = ccr_m[1]; c = ccr_m[2]; v = ccr_m[3];
        ill = 1'b0; zn = 1'b1; r = 8'h00;
        case (fun)
            4'd0, 4'd6: begin
                if (fun == 4'd0) cin = 0;
                s = ia + ib + cin; r = s[7:0]; c = (s > 255);
                sr = sval(ia) + sval(ib) + cin; v = (sr > 127) || (sr < -128);
            end
            4'd1, 4'd7: begin
                if (fun == 4'd1) cin = 0;
                s = ia - ib - cin; r = s[7:0]; c = (s < 0);
                sr = sval(ia) - sval(ib) - cin; v = (sr > 127) || (sr < -128);
            end
            4'd2: r = av & bv;
            4'd3: r = av | bv;
            4'd4: begin
                if (sop == 2'd0) s = 255 - ib;
                else if (sop == 2'd1) s = 256 - ib;
                else if (sop == 2'd2) s = ib + 1;
                else s = ib + 255;
                r = s[7:0];
            end
            4'd5: begin
                zn = 1'b0;
                if (sop == 2'd0) begin r = (bv << 1) | {7'd0, ccr_m[2]}; c = bv[7]; end
                else if (sop == 2'd1) begin r = (bv >> 1) | {ccr_m[2], 7'd0}; c = bv[0]; end
                else if (sop == 2'd2) begin r = bv; c = 1'b1; end
                else begin r = bv; c = 1'b0; end
            end
            default: begin ill = 1'b1; zn = 1'b0; r = 8'h00; c = ccr_m[2]; v = ccr_m[3]; end
        endcase
        if (zn) begin z = (r == 8'h00); n = r[7]; end
        e.r = r;
        e.ill = ill;
        e.f = we ? din : {v, c, n, z};
        ccr_m = e.f;
        last_r = r;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs at the falling edge, then step past the rising edge.
    task automatic drive(input logic iv, input logic [3:0] fun, input logic [1:0] sop,
                         input logic [7:0] av, input logic [7:0] bv, input logic we,
                         input logic [3:0] din);
        @(negedge clk);
        in_valid = iv; alu_fun = fun; sub_op = sop; a = av; b = bv;
        flag_we = we; flag_din = din;
        if (iv && !stall && !reset) push_op(fun, sop, av, bv, we, din);
        else if (!stall && !reset && we) ccr_m = din;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; stall = 1'b0;
        drive(1'b0, 4'd0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0);
        drive(1'b0, 4'd0, 2'd0, 8'h00, 8'h00, 1'b0, 4'd0);
        ccr_m = 4'b0000; last_r = 8'h00;
        n_run++;
        if (out_valid !== 1'b0 || alu_out !== 8'h00 || flags !== 4'b0000 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init got v=%b r=%h f=%b ill=%b exp 0/00/0000/0", out_valid, alu_out, flags, illegal_op);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 2'd0, 8'h90 + 8'(i * 16), 8'hA0, 1'b0, 4'd0);
            exp_v = sb.pop_front();
            n_run++;
            if (out_valid !== 1'b1 || alu_out !== exp_v.r || flags !== exp_v.f || illegal_op !== exp_v.ill) begin
                n_fail++;
                $display("FAIL reset_pre_add[%0d] got v=%b r=%h f=%b exp v=1 r=%h f=%b", i, out_valid, alu_out, flags, exp_v.r, exp_v.f);
            end
        end
        reset = 1'b1;
        drive(1'b1, 4'd0, 2'd0, 8'h11, 8'h22, 1'b0, 4'd0);
        ccr_m = 4'b0000; last_r = 8'h00;
        n_run++;
        if (out_valid !== 1'b0 || alu_out !== 8'h00 || flags !== 4'b0000 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b r=%h f=%b exp 0/00/0000", out_valid, alu_out, flags);
        end
        reset = 1'b0;
    endtask

    task automatic test_add;
        logic [7:0] av [2];
        logic [7:0] rv [2];
        logic [3:0] fv [2];
        av[0] = 8'h7F; rv[0] = 8'h80; fv[0] = 4'b1010;
        av[1] = 8'hFF; rv[1] = 8'h00; fv[1] = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'd0, 2'd0, av[i], 8'h01, 1'b0, 4'd0);
            exp_v = sb.pop_front();
            n_run++;
            if (out_valid !== 1'b1 || alu_out !== rv[i] || flags !== fv[i] || alu_out !== exp_v.r || flags !== exp_v.f) begin
                n_fail++;
                $display("FAIL add[%0d] got r=%h f=%b exp r=%h f=%b", i, alu_out, flags, rv[i], fv[i]);
            end
        end
    endtask

    task automatic test_adc_chain;
        logic [3:0] fun [2];
        logic [7:0] av [2];
        logic [7:0] rv [2];
        fun[0] = 4'd0; av[0] = 8'hFF; rv[0] = 8'h00;
        fun[1] = 4'd6; av[1] = 8'h00; rv[1] = 8'h01;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, fun[i], 2'd0, av[i], (i == 0) ? 8'h01 : 8'h00, 1'b0, 4'd0);
            exp_v = sb.pop_front();
            n_run++;
            if (out_valid !== 1'b1 || alu_out !== rv[i] || alu_out !== exp_v.r || flags !== exp_v.f) begin
                n_fail++;
                $display("FAIL adc_chain[%0d] got r=%h f=%b exp r=%h f=%b", i, alu_out, flags, rv[i], exp_v.f);
            end
        end
        n_run++;
        if (flags[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL adc_chain_c got C=%b exp C=0", flags[2]);
        end
    endtask

    task automatic test_rotate;
        logic [3:0] fun [4];
        logic [1:0] sop [4];
        logic [7:0] bv [4];
        fun[0] = 4'd5; sop[0] = 2'd2; bv[0] = 8'h33;
        fun[1] = 4'd5; sop[1] = 2'd0; bv[1] = 8'h80;
        fun[2] = 4'd5; sop[2] = 2'd1; bv[2] = 8'h00;
        fun[3] = 4'd2; sop[3] = 2'd0; bv[3] = 8'h0F;
        drive(1'b1, 4'd0, 2'd0, 8'h7F, 8'h01, 1'b0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fun[i], sop[i], 8'hF0, bv[i], 1'b0, 4'd0);
            exp_v = sb.pop_front();
            n_run++;
            if (out_valid !== 1'b1 || alu_out !== exp_v.r || flags !== exp_v.f || illegal_op !== 1'b0) begin
                n_fail++;
                $display("FAIL rotate[%0d] got r=%h f=%b exp r=%h f=%b", i, alu_out, flags, exp_v.r, exp_v.f);
            end
        end
        n_run++;
        if (flags !== 4'b1001) begin
            n_fail++;
            $display("FAIL rotate_final got f=%b exp f=1001", flags);
        end
    endtask

    task automatic test_stall;
        exp_t prev;
        drive(1'b1, 4'd3, 2'd0, 8'h12, 8'h40, 1'b0, 4'd0);
        prev = sb.pop_front();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 2'd0, 8'hFF, 8'hFF, 1'b1, 4'b1111);
            n_run++;
            if (out_valid !== 1'b1 || alu_out !== prev.r || flags !== prev.f) begin
                n_fail++;
                $display("FAIL stall[%0d] got v=%b r=%h f=%b exp v=1 r=%h f=%b", i, out_valid, alu_out, flags, prev.r, prev.f);
            end
        end
        stall = 1'b0;
        drive(1'b1, 4'd0, 2'd0, 8'hFF, 8'hFF, 1'b0, 4'd0);
        exp_v = sb.pop_front();
        n_run++;
        if (out_valid !== 1'b1 || alu_out !== exp_v.r || flags !== exp_v.f || alu_out !== 8'hFE) begin
            n_fail++;
            $display("FAIL stall_release got r=%h f=%b exp r=%h f=%b", alu_out, flags, exp_v.r, exp_v.f);
        end
    endtask

    task automatic test_flag_we_illegal;
        drive(1'b1, 4'd1, 2'd0, 8'h05, 8'h05, 1'b1, 4'b1010);
        exp_v = sb.pop_front();
        n_run++;
        if (out_valid !== 1'b1 || alu_out !== 8'h00 || flags !== 4'b1010 || flags !== exp_v.f) begin
            n_fail++;
            $display("FAIL flag_we got r=%h f=%b exp r=00 f=1010", alu_out, flags);
        end
        drive(1'b1, 4'b1001, 2'd0, 8'h33, 8'h44, 1'b0, 4'd0);
        exp_v = sb.pop_front();
        n_run++;
        if (out_valid !== 1'b1 || illegal_op !== 1'b1 || alu_out !== 8'h00 || flags !== 4'b1010 || exp_v.ill !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal got v=%b ill=%b r=%h f=%b exp 1/1/00/1010", out_valid, illegal_op, alu_out, flags);
        end
        drive(1'b0, 4'd0, 2'd0, 8'h00, 8'h00, 1'b1, 4'b0110);
        n_run++;
        if (out_valid !== 1'b0 || illegal_op !== 1'b0 || alu_out !== 8'h00 || flags !== 4'b0110) begin
            n_fail++;
            $display("FAIL idle_restore got v=%b ill=%b r=%h f=%b exp 0/0/00/0110", out_valid, illegal_op, alu_out, flags);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] fun;
        logic       we;
        for (int i = 0; i < 200; i++) begin
            we = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 4) == 0) begin
                drive(1'b0, 4'd0, 2'd0, 8'h00, 8'h00, we, 4'($urandom));
                n_run++;
                if (out_valid !== 1'b0 || illegal_op !== 1'b0 || alu_out !== last_r || flags !== ccr_m) begin
                    n_fail++;
                    $display("FAIL b2b_idle[%0d] got v=%b r=%h f=%b exp v=0 r=%h f=%b", i, out_valid, alu_out, flags, last_r, ccr_m);
                end
            end else begin
                fun = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                drive(1'b1, fun, 2'($urandom), 8'($urandom), 8'($urandom), we, 4'($urandom));
                exp_v = sb.pop_front();
                n_run++;
                if (out_valid !== 1'b1 || alu_out !== exp_v.r || flags !== exp_v.f || illegal_op !== exp_v.ill) begin
                    n_fail++;
                    $display("FAIL b2b[%0d] fun=%b a=%h b=%h got r=%h f=%b ill=%b exp r=%h f=%b ill=%b",
                             i, alu_fun, a, b, alu_out, flags, illegal_op, exp_v.r, exp_v.f, exp_v.ill);
                end
            end
        end
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        reset = 1'b1; stall = 1'b0; in_valid = 1'b0; alu_fun = 4'd0; sub_op = 2'd0;
        a = 8'h00; b = 8'h00; flag_we = 1'b0; flag_din = 4'd0;
        ccr_m = 4'b0000; last_r = 8'h00;
        test_reset();
        test_add();
        test_adc_chain();
        test_rotate();
        test_stall();
        test_flag_we_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
